ysyx_22041211_sram_resp: RTL
============================

# ysyx_22041211_sram_resp

Memory-side responder for the core's load/store data port. Receives read and write requests, with byte masks, from the LSU request signals (mem_ren/mem_raddr/mem_rmask, mem_wen/mem_waddr/mem_wdata/mem_wmask). Serves them from an internal word array after a fixed, parameterised latency, and signals completion with single-cycle response pulses. It replaces the zero-latency behavioural memory in simulation and gives the LSU a real multi-cycle handshake to wait on.

## Interface
- DATA_LEN, 32, data word width
- ADDR_LEN, 32, byte-address width
- DEPTH, 1024, number of 32-bit words in the array
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from request accept to response pulse; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ren_i  in  1  read request
- raddr_i  in  ADDR_LEN  read byte address
- rmask_i  in  8  read byte-lane mask; bits [3:0] are used, bits [7:4] are ignored
- wen_i  in  1  write request
- waddr_i  in  ADDR_LEN  write byte address
- wdata_i  in  DATA_LEN  write data, already lane-aligned
- wmask_i  in  8  write byte enables; bits [3:0] are used, bits [7:4] are ignored
- req_ready_o  out  1  responder can accept a request this cycle
- rvalid_o  out  1  one-cycle pulse: rdata_o is valid
- rdata_o  out  DATA_LEN  read data
- bvalid_o  out  1  one-cycle pulse: the write has been committed
- err_o  out  1  qualifies rvalid_o or bvalid_o; the address was out of range

## Operation
- States:
  - IDLE: req_ready_o=1.
  - BUSY: latency countdown; req_ready_o=0.
  - RESP: response cycle; req_ready_o=0.
- Accept: a request is accepted on a rising edge in IDLE when ren_i or wen_i is high.
  - Latched at accept: kind (read/write), address, wdata, mask[3:0].
- Simultaneous ren_i and wen_i in IDLE: the read is accepted. The write is not consumed; the initiator holds wen_i and the write is accepted on a later IDLE edge.
- Index: word index = (addr − BASE_ADDR) >> 2, with addr[1:0] ignored.
  - In range when BASE_ADDR ≤ addr and (addr − BASE_ADDR) < 4·DEPTH, computed in ADDR_LEN-bit unsigned arithmetic.
  - Below-base addresses are out of range; wrap-around of the subtraction must not alias into the array.
- Counter: loaded with LATENCY−1 at accept.
  - If LATENCY=1, go IDLE→RESP directly.
  - Otherwise IDLE→BUSY; BUSY decrements each cycle and moves to RESP when the count reaches 1.
- RESP, read: rvalid_o=1. rdata_o = array word with lane k zeroed where mask[k]=0.
- RESP, write: bvalid_o=1. Array lanes with mask[k]=1 are written on the edge that leaves RESP.
- Out of range: no array write, rdata_o=0, err_o=1 alongside the valid pulse.
- mask[3:0]=0 is legal.
  - Read: returns 0, err_o=0.
  - Write: changes nothing; bvalid_o still pulses.
- RESP always returns to IDLE on the next edge. The response has no back-pressure.
- Request inputs are ignored outside IDLE.

## Timing
- Reset (rst=0, asynchronous):
  - State=IDLE, counter=0.
  - req_ready_o=0, rvalid_o=0, bvalid_o=0, err_o=0, rdata_o=0.
  - Array contents are not reset.
- req_ready_o rises combinationally from state once rst=1, i.e. in the first cycle after release.
- Reset asserted mid-transaction: the pending request is discarded, no response is produced, and a pending write is not committed.
- Latency: a request accepted at edge N gives a response pulse in the cycle after edge N+LATENCY−1. A write is visible to a read accepted at edge N+LATENCY or later.
- Throughput: one request per LATENCY+1 cycles. req_ready_o is low from the cycle after accept through RESP.
- rdata_o holds its last value between pulses; it is valid only when rvalid_o=1.

## Test plan
- Reset/idle:
  - Stimulus: assert rst=0 mid-BUSY of a write to 0x8000_0010, then release.
  - Required: all outputs 0 during reset; req_ready_o=1 the cycle after release; a read of 0x8000_0010 returns the old word.
- Word write and read, LATENCY=2:
  - Stimulus: write 0xDEAD_BEEF to 0x8000_0004 with mask 0x0F, then read it with mask 0x0F.
  - Required: bvalid_o 2 cycles after accept; rvalid_o 2 cycles after the read accept; rdata_o=0xDEAD_BEEF; err_o=0.
- Byte lanes:
  - Stimulus: write 0x0000_AB00 with mask 0x02 over 0x1122_3344, then read with mask 0x0F and again with mask 0x03.
  - Required: first read 0x1122_AB44; second read 0x0000_AB44.
- Simultaneous requests:
  - Stimulus: ren_i and wen_i high in the same IDLE cycle at the same address.
  - Required: the read is served first and returns pre-write data; the write is accepted next and bvalid_o follows.
- Range errors:
  - Stimulus: read 0x7FFF_FFFC; write at 0x8000_1000 (DEPTH=1024).
  - Required: err_o=1 on both responses; read data 0; array unchanged.
- LATENCY=1 build:
  - Stimulus: back-to-back reads held continuously.
  - Required: rvalid_o every 2nd cycle; req_ready_o toggles 1,0.

Source files
------------

// File: rtl/ysyx_22041211_sram_resp.sv
// Memory-side responder for the LSU data port: fixed-latency word array with
// byte masks, single-cycle rvalid/bvalid pulses and an out-of-range error flag.
module ysyx_22041211_sram_resp #(
  parameter int                  DATA_LEN  = 32,
  parameter int                  ADDR_LEN  = 32,
  parameter int                  DEPTH     = 1024,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ren_i,
  input  logic [ADDR_LEN-1:0] raddr_i,
  input  logic [7:0]          rmask_i,
  input  logic                wen_i,
  input  logic [ADDR_LEN-1:0] waddr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [7:0]          wmask_i,
  output logic                req_ready_o,
  output logic                rvalid_o,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                bvalid_o,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_LEN-1:0] SPAN     = ADDR_LEN'(4 * DEPTH);
  localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                is_wr_q;
  logic                in_range_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [3:0]          mask_q;
  logic [DATA_LEN-1:0] rdata_hold;

  logic [DATA_LEN-1:0] mem [DEPTH];

  logic [ADDR_LEN-1:0] acc_addr;
  logic [ADDR_LEN-1:0] acc_off;
  logic                acc_in_range;
  logic [3:0]          acc_mask;
  logic [DATA_LEN-1:0] rd_word;
  logic [DATA_LEN-1:0] rd_masked;
  logic                unused_bits;

  // A read wins over a simultaneous write; the base check keeps below-base
  // addresses from wrapping into the array through the subtraction.
  always_comb begin
    acc_addr     = ren_i ? raddr_i : waddr_i;
    acc_off      = acc_addr - BASE_ADDR;
    acc_in_range = (acc_addr >= BASE_ADDR) && (acc_off < SPAN);
    acc_mask     = ren_i ? rmask_i[3:0] : wmask_i[3:0];
  end

  always_comb begin
    rd_word   = mem[idx_q];
    rd_masked = '0;
    if (in_range_q) begin
      for (int k = 0; k < 4; k++) begin
        if (mask_q[k]) rd_masked[8*k +: 8] = rd_word[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_wr_q    <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ren_i || wen_i) begin
            is_wr_q    <= !ren_i;
            in_range_q <= acc_in_range;
            idx_q      <= acc_off[IDX_W+1:2];
            wdata_q    <= wdata_i;
            mask_q     <= acc_mask;
            cnt        <= CNT_INIT;
            state      <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (!is_wr_q) rdata_hold <= rd_masked;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes commit on the edge that leaves RESP, so a reset before then drops them.
  always_ff @(posedge clk) begin
    if (state == RESP && is_wr_q && in_range_q) begin
      for (int k = 0; k < 4; k++) begin
        if (mask_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign req_ready_o = rst && (state == IDLE);
  assign rvalid_o    = (state == RESP) && !is_wr_q;
  assign bvalid_o    = (state == RESP) && is_wr_q;
  assign err_o       = (state == RESP) && !in_range_q;
  assign rdata_o     = rvalid_o ? rd_masked : rdata_hold;

  assign unused_bits = ^{rmask_i[7:4], wmask_i[7:4], acc_off[1:0],
                         acc_off[ADDR_LEN-1:IDX_W+2]};

endmodule
